// File: rtl/mem_pkg.sv
// Shared types and constants for the memory stage and its store buffer.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      READ  = 2'd2,
      RESP  = 2'd3
   } state_e;

   localparam int unsigned WORD_LSB = 2;

endpackage

// File: rtl/sb_fifo.sv
// Store-buffer FIFO: word address + data per entry, with a parallel
// address compare that returns the youngest matching entry.
module sb_fifo
   import mem_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned WA_W   = 30,
   parameter int unsigned DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic [WA_W-1:0]   push_addr_i,
   input  logic [DATA_W-1:0] push_data_i,
   input  logic              pop_i,
   input  logic [WA_W-1:0]   lookup_addr_i,
   output logic [WA_W-1:0]   head_addr_o,
   output logic [DATA_W-1:0] head_data_o,
   output logic              hit_o,
   output logic [DATA_W-1:0] hit_data_o,
   output logic              full_o,
   output logic              empty_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WA_W-1:0]   addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [PTR_W-1:0]  head_q, tail_q, slot;
   logic [CNT_W-1:0]  count_q;

   assign full_o      = (count_q == CNT_W'(DEPTH));
   assign empty_o     = (count_q == '0);
   assign head_addr_o = addr_q[head_q];
   assign head_data_o = data_q[head_q];

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_i) tail_q <= tail_q + PTR_W'(1);
         if (pop_i)  head_q <= head_q + PTR_W'(1);
         count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) begin
         addr_q[tail_q] <= push_addr_i;
         data_q[tail_q] <= push_data_i;
      end
   end

   // Walk oldest to youngest so the last match (nearest tail) wins.
   always_comb begin
      hit_o      = 1'b0;
      hit_data_o = '0;
      slot       = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         slot = head_q + PTR_W'(k);
         if ((CNT_W'(k) < count_q) && (addr_q[slot] == lookup_addr_i)) begin
            hit_o      = 1'b1;
            hit_data_o = data_q[slot];
         end
      end
   end

endmodule

// File: rtl/mem_stage_sb.sv
// MEM stage front end: posts stores into a buffer, forwards or fetches
// loads, and drains the buffer to the backing port when it is free.
module mem_stage_sb
   import mem_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DEPTH  = 4,
   parameter bit          FWD_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MEM_R_EN,
   input  logic              MEM_W_EN,
   input  logic [ADDR_W-1:0] ALU_result_in,
   input  logic [DATA_W-1:0] ST_val,
   output logic [DATA_W-1:0] Mem_read_value,
   output logic              ready,
   output logic              sb_empty,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   localparam int unsigned WA_W = ADDR_W - WORD_LSB;

   state_e            state_q;
   logic [DATA_W-1:0] rdata_q;
   logic [WA_W-1:0]   word_addr, head_addr;
   logic [DATA_W-1:0] head_data, hit_data;
   logic              hit, full, empty, push, pop, is_load, fwd, miss;
   logic              unused_lsb;

   assign word_addr  = ALU_result_in[ADDR_W-1:WORD_LSB];
   assign unused_lsb = ^ALU_result_in[WORD_LSB-1:0];

   // A simultaneous load and store is resolved as a store.
   assign is_load = MEM_R_EN && !MEM_W_EN;
   assign push    = MEM_W_EN && !full;
   assign pop     = (state_q == DRAIN) && mem_ack;
   assign fwd     = FWD_EN && is_load && hit;
   assign miss    = is_load && !hit;

   assign ready          = MEM_W_EN ? !full
                         : is_load  ? (fwd || (state_q == RESP))
                         : 1'b1;
   assign Mem_read_value = fwd ? hit_data : rdata_q;
   assign sb_empty       = empty && (state_q != DRAIN);

   sb_fifo #(
      .DATA_W (DATA_W),
      .WA_W   (WA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk           (clk),
      .rst           (rst),
      .push_i        (push),
      .push_addr_i   (word_addr),
      .push_data_i   (ST_val),
      .pop_i         (pop),
      .lookup_addr_i (word_addr),
      .head_addr_o   (head_addr),
      .head_data_o   (head_data),
      .hit_o         (hit),
      .hit_data_o    (hit_data),
      .full_o        (full),
      .empty_o       (empty)
   );

   // Backing-port sequencer; a pending load miss wins over draining.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rdata_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (miss) begin
                  state_q  <= READ;
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= {word_addr, {WORD_LSB{1'b0}}};
               end else if (!empty) begin
                  state_q   <= DRAIN;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_addr  <= {head_addr, {WORD_LSB{1'b0}}};
                  mem_wdata <= head_data;
               end
            end
            DRAIN: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  state_q <= IDLE;
               end
            end
            READ: begin
               if (mem_ack) begin
                  rdata_q <= mem_rdata;
                  mem_req <= 1'b0;
                  state_q <= RESP;
               end
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_sb.sv
// Directed bench for mem_stage_sb: one forwarding instance, one non-forwarding.
module tb_mem_stage_sb;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 32;
   localparam int unsigned D  = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, r_en, w_en, ack1, ack0;
   logic [AW-1:0] addr;
   logic [DW-1:0] st_val, rdata;
   logic [DW-1:0] rv1, wd1, rv0, wd0;
   logic [AW-1:0] ma1, ma0;
   logic          rdy1, sbe1, req1, we1, rdy0, sbe0, req0, we0;

   int pass_cnt = 0;
   int tot_cnt  = 0;

   mem_stage_sb #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D), .FWD_EN(1'b1)) dut1 (
      .clk(clk), .rst(rst), .MEM_R_EN(r_en), .MEM_W_EN(w_en),
      .ALU_result_in(addr), .ST_val(st_val), .Mem_read_value(rv1),
      .ready(rdy1), .sb_empty(sbe1), .mem_req(req1), .mem_we(we1),
      .mem_addr(ma1), .mem_wdata(wd1), .mem_rdata(rdata), .mem_ack(ack1));

   mem_stage_sb #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D), .FWD_EN(1'b0)) dut0 (
      .clk(clk), .rst(rst), .MEM_R_EN(r_en), .MEM_W_EN(w_en),
      .ALU_result_in(addr), .ST_val(st_val), .Mem_read_value(rv0),
      .ready(rdy0), .sb_empty(sbe0), .mem_req(req0), .mem_we(we0),
      .mem_addr(ma0), .mem_wdata(wd0), .mem_rdata(rdata), .mem_ack(ack0));

   always @(posedge clk)
      if (!rst) assert (!(r_en && w_en)) else $error("illegal simultaneous load and store");

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; r_en = 1'b0; w_en = 1'b0; addr = '0; st_val = '0;
      rdata = '0; ack1 = 1'b0; ack0 = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      tot_cnt++; if (rdy1 !== 1'b1) $display("FAIL rst_ready got %b want 1", rdy1); else pass_cnt++;
      tot_cnt++; if (sbe1 !== 1'b1) $display("FAIL rst_sb_empty got %b want 1", sbe1); else pass_cnt++;
      tot_cnt++; if (rv1 !== 32'h0) $display("FAIL rst_rdval got %h want 0", rv1); else pass_cnt++;
      tot_cnt++; if ({req1, we1} !== 2'b00) $display("FAIL rst_req_we got %b want 00", {req1, we1}); else pass_cnt++;
      tot_cnt++; if ({ma1, wd1} !== 64'h0) $display("FAIL rst_addr_wdata got %h want 0", {ma1, wd1}); else pass_cnt++;
      tot_cnt++; if ({rdy0, sbe0, req0} !== 3'b110) $display("FAIL rst_nofwd got %b want 110", {rdy0, sbe0, req0}); else pass_cnt++;
   endtask

   task automatic test_store_drain();
      logic [AW-1:0] sa [3];
      logic [DW-1:0] sd [3];
      logic [AW-1:0] wa [4];
      logic [DW-1:0] wv [4];
      int nw = 0;
      int wt = 0;
      sa = '{32'h10, 32'h14, 32'h18};
      sd = '{32'hAAAA0001, 32'h2, 32'h3};
      do_reset();
      for (int c = 0; c < 30; c++) begin
         tick();
         ack1 = 1'b0;
         if (req1) begin if (wt == 2) ack1 = 1'b1; wt++; end else wt = 0;
         w_en = (c < 3);
         if (c < 3) begin addr = sa[c]; st_val = sd[c]; end
         #1;
         if (c < 3) begin
            tot_cnt++; if (rdy1 !== 1'b1) $display("FAIL st_ready c=%0d got %b want 1", c, rdy1); else pass_cnt++;
         end
         if (ack1 && we1) begin
            if (nw < 4) begin wa[nw] = ma1; wv[nw] = wd1; end
            nw++;
         end
      end
      ack1 = 1'b0;
      tot_cnt++; if (nw !== 3) $display("FAIL drain_count got %0d want 3", nw); else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         tot_cnt++;
         if (wa[i] !== sa[i] || wv[i] !== sd[i])
            $display("FAIL drain_order i=%0d got %h=%h want %h=%h", i, wa[i], wv[i], sa[i], sd[i]);
         else pass_cnt++;
      end
      tot_cnt++; if (sbe1 !== 1'b1) $display("FAIL drain_sb_empty got %b want 1", sbe1); else pass_cnt++;
   endtask

   task automatic test_full();
      do_reset();
      for (int c = 0; c < 9; c++) begin
         tick();
         ack1   = (c == 6);
         w_en   = 1'b1;
         addr   = (c == 8) ? 32'h200 : 32'h100 + 32'(4 * ((c < 4) ? c : 4));
         st_val = 32'(c);
         #1;
         if (c < 4) begin
            tot_cnt++; if (rdy1 !== 1'b1) $display("FAIL full_ready c=%0d got %b want 1", c, rdy1); else pass_cnt++;
         end
         if (c == 4) begin
            tot_cnt++; if (rdy1 !== 1'b0) $display("FAIL full_block got %b want 0", rdy1); else pass_cnt++;
            tot_cnt++; if ({req1, ma1} !== {1'b1, 32'h100}) $display("FAIL full_head got %b/%h want 1/100", req1, ma1); else pass_cnt++;
         end
         if (c == 6) begin
            tot_cnt++; if (rdy1 !== 1'b0) $display("FAIL full_ack_bubble got %b want 0", rdy1); else pass_cnt++;
         end
         if (c == 7) begin
            tot_cnt++; if (rdy1 !== 1'b1) $display("FAIL full_after_ack got %b want 1", rdy1); else pass_cnt++;
         end
         if (c == 8) begin
            tot_cnt++; if (rdy1 !== 1'b0) $display("FAIL full_refilled got %b want 0", rdy1); else pass_cnt++;
            tot_cnt++; if ({req1, we1, ma1} !== {2'b11, 32'h104}) $display("FAIL full_next_drain got %b%b/%h want 11/104", req1, we1, ma1); else pass_cnt++;
         end
      end
      w_en = 1'b0; ack1 = 1'b0;
   endtask

   task automatic test_forward();
      do_reset();
      tick(); w_en = 1'b1; addr = 32'h20; st_val = 32'h11; #1;
      tick(); st_val = 32'h22; #1;
      tick(); w_en = 1'b0; r_en = 1'b1; #1;
      tot_cnt++; if (rdy1 !== 1'b1) $display("FAIL fwd_ready got %b want 1", rdy1); else pass_cnt++;
      tot_cnt++; if (rv1 !== 32'h22) $display("FAIL fwd_youngest got %h want 22", rv1); else pass_cnt++;
      tot_cnt++; if ({req1, we1} !== 2'b11) $display("FAIL fwd_no_read got %b%b want 11", req1, we1); else pass_cnt++;
      tick(); addr = 32'h24; #1;
      tot_cnt++; if (rdy1 !== 1'b0) $display("FAIL fwd_miss_waits got %b want 0", rdy1); else pass_cnt++;
      r_en = 1'b0;
   endtask

   task automatic test_nofwd();
      int nw = 0, wt = 0, rd_nw = -1;
      bit done = 1'b0, rd_seen = 1'b0;
      logic [AW-1:0] rd_addr = '0;
      do_reset();
      rdata = 32'h22;
      for (int c = 0; c < 40 && !done; c++) begin
         tick();
         ack0 = 1'b0;
         if (req0) begin if (wt == 1) ack0 = 1'b1; wt++; end else wt = 0;
         if (c < 2) begin
            w_en = 1'b1; addr = 32'h20; st_val = (c == 0) ? 32'h11 : 32'h22;
         end else begin
            w_en = 1'b0; r_en = 1'b1; addr = 32'h20;
         end
         #1;
         if (req0 && !we0 && !rd_seen) begin rd_seen = 1'b1; rd_addr = ma0; rd_nw = nw; end
         if (ack0 && we0) nw++;
         if (c == 2) begin
            tot_cnt++; if (rdy0 !== 1'b0) $display("FAIL nofwd_stall got %b want 0", rdy0); else pass_cnt++;
         end
         if (c > 2 && rdy0) begin
            done = 1'b1;
            tot_cnt++; if (rv0 !== 32'h22) $display("FAIL nofwd_value got %h want 22", rv0); else pass_cnt++;
            tot_cnt++; if (!rd_seen || rd_addr !== 32'h20) $display("FAIL nofwd_read_addr got %b/%h want 1/20", rd_seen, rd_addr); else pass_cnt++;
            tot_cnt++; if (rd_nw !== 2) $display("FAIL nofwd_read_after_drain got %0d want 2", rd_nw); else pass_cnt++;
         end
      end
      tot_cnt++; if (!done) $display("FAIL nofwd_timeout got no ready want ready"); else pass_cnt++;
      r_en = 1'b0; ack0 = 1'b0;
   endtask

   task automatic test_miss();
      int wt = 0;
      do_reset();
      rdata = 32'hDEADBEEF;
      for (int c = 0; c < 9; c++) begin
         tick();
         ack1 = 1'b0;
         if (req1) begin if (wt == 3) ack1 = 1'b1; wt++; end else wt = 0;
         w_en = (c == 0); addr = (c == 0) ? 32'h80 : 32'h40; st_val = 32'h5A;
         r_en = (c >= 1 && c <= 6);
         #1;
         if (c >= 1 && c <= 5) begin
            tot_cnt++; if (rdy1 !== 1'b0) $display("FAIL miss_wait l=%0d got %b want 0", c - 1, rdy1); else pass_cnt++;
         end
         if (c == 2) begin
            tot_cnt++; if ({req1, we1, ma1} !== {2'b10, 32'h40}) $display("FAIL miss_read_req got %b%b/%h want 10/40", req1, we1, ma1); else pass_cnt++;
         end
         if (c == 6) begin
            tot_cnt++; if (rdy1 !== 1'b1 || rv1 !== 32'hDEADBEEF) $display("FAIL miss_resp got %b/%h want 1/deadbeef", rdy1, rv1); else pass_cnt++;
            tot_cnt++; if (sbe1 !== 1'b0) $display("FAIL miss_store_held got %b want 0", sbe1); else pass_cnt++;
            r_en = 1'b0;
         end
         if (c == 7) begin
            tot_cnt++; if (req1 !== 1'b0) $display("FAIL miss_idle_gap got %b want 0", req1); else pass_cnt++;
         end
         if (c == 8) begin
            tot_cnt++; if ({req1, we1, ma1, wd1} !== {2'b11, 32'h80, 32'h5A}) $display("FAIL miss_then_drain got %b%b/%h/%h want 11/80/5a", req1, we1, ma1, wd1); else pass_cnt++;
         end
      end
      r_en = 1'b0; ack1 = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      tick(); r_en = 1'b1; addr = 32'h40; #1;
      tick(); #1;
      tot_cnt++; if ({req1, we1} !== 2'b10) $display("FAIL rm_read_active got %b%b want 10", req1, we1); else pass_cnt++;
      tick(); r_en = 1'b0; rst = 1'b1; #1;
      tick(); rst = 1'b0; ack1 = 1'b1; rdata = 32'h12345678; #1;
      tot_cnt++; if ({req1, sbe1, rdy1} !== 3'b011) $display("FAIL rm_read_abort got %b want 011", {req1, sbe1, rdy1}); else pass_cnt++;
      tick(); ack1 = 1'b0; #1;
      tot_cnt++; if ({req1, rv1} !== {1'b0, 32'h0}) $display("FAIL rm_stray_capture got %b/%h want 0/0", req1, rv1); else pass_cnt++;

      tick(); w_en = 1'b1; addr = 32'h200; st_val = 32'h1; #1;
      tick(); addr = 32'h204; st_val = 32'h2; #1;
      tick(); w_en = 1'b0; rst = 1'b1; #1;
      tot_cnt++; if ({req1, we1, sbe1} !== 3'b110) $display("FAIL rm_drain_active got %b want 110", {req1, we1, sbe1}); else pass_cnt++;
      tick(); rst = 1'b0; ack1 = 1'b1; #1;
      tot_cnt++; if ({req1, sbe1} !== 2'b01) $display("FAIL rm_drain_abort got %b want 01", {req1, sbe1}); else pass_cnt++;
      tick(); ack1 = 1'b0; r_en = 1'b1; addr = 32'h200; #1;
      tot_cnt++; if ({rdy1, sbe1, req1} !== 3'b010) $display("FAIL rm_entries_gone got %b want 010", {rdy1, sbe1, req1}); else pass_cnt++;
      tick(); r_en = 1'b0; #1;
   endtask

   initial begin
      test_reset();
      test_store_drain();
      test_full();
      test_forward();
      test_nofwd();
      test_miss();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
